serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 29 ++
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_serial_adder_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side bundle of the bit-serial adder: operands and start in, status and result out.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
    import serial_adder_pkg::*;

    // Handshake: start is taken on any clock edge where the sequencer is IDLE or DONE and
    // ignored while busy; done pulses for one cycle with sum/cout valid, and they hold after.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    state_t           state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, state
    );

endinterface

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder, time-shared by the serial sequencer.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Adds two WIDTH-bit operands LSB first, one bit per clock, through a single full adder cell.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic          clk,
    input logic          rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cell_sum;
    logic             cell_cout;
    logic             accept;
    logic             last_bit;

    full_adder_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // New sum bit enters at the MSB so the finished word lines up without a final shift.
    if (WIDTH == 1) begin : g_res_one
        assign res_shift = cell_sum;
    end else begin : g_res_wide
        assign res_shift = {cell_sum, res_sh[WIDTH-1:1]};
    end

    assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
            end else if (state_q == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_shift;
                carry  <= cell_cout;
                cnt    <= cnt + CNT_W'(1);
                // Outputs only ever see the completed word, never partial bits.
                if (last_bit) begin
                    sum_q  <= res_shift;
                    cout_q <= cell_cout;
                end
            end
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for the serial adder at WIDTH=8 and WIDTH=1 with a queued scoreboard.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic [8:0] exp8_q[$];
    int         t8_q[$];
    logic [1:0] exp1_q[$];
    int         t1_q[$];

    serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) if1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // monitors: pop and compare whenever a DUT presents done
    always @(negedge clk) begin
        logic [8:0] e;
        int         t;
        if (rst === 1'b0 && if8.done === 1'b1) begin
            if (exp8_q.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
            else begin
                e = exp8_q.pop_front();
                t = t8_q.pop_front();
                chk("result8", 32'({if8.cout, if8.sum}), 32'(e));
                chk("latency8", 32'(cyc), 32'(t));
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        int         t;
        if (rst === 1'b0 && if1.done === 1'b1) begin
            if (exp1_q.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
            else begin
                e = exp1_q.pop_front();
                t = t1_q.pop_front();
                chk("result1", 32'({if1.cout, if1.sum}), 32'(e));
                chk("latency1", 32'(cyc), 32'(t));
            end
        end
    end

    // driver tasks, called on a falling edge
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = c;
        if (push) begin
            exp8_q.push_back(9'(a) + 9'(b) + 9'(c));
            t8_q.push_back(cyc + 1 + 8);
        end
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic wait_done8();
        int n = 0;
        while (if8.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("timeout8", 32'd0, 32'd1);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (if1.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("timeout1", 32'd0, 32'd1);
    endtask

    logic [1:0] tbl1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", 32'(if8.busy), 32'd0);
        chk("rst_done8", 32'(if8.done), 32'd0);
        chk("rst_sum8", 32'(if8.sum), 32'd0);
        chk("rst_cout8", 32'(if8.cout), 32'd0);
        chk("rst_state8", 32'(if8.state), 32'(IDLE));
        chk("rst_busy1", 32'(if1.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3C + 0F: busy for 8 cycles, done on the 9th
        issue8(8'h3C, 8'h0F, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", 32'(if8.busy), 32'd1);
            chk("done_low_run", 32'(if8.done), 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", 32'(if8.done), 32'd1);
        chk("busy_in_done", 32'(if8.busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(if8.done), 32'd0);

        // FF + 01, then A5 + 5A + 1 started in the DONE cycle
        issue8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done8();
        issue8(8'hA5, 8'h5A, 1'b1, 1'b1);
        chk("b2b_busy", 32'(if8.busy), 32'd1);
        wait_done8();
        @(negedge clk);

        // start held through RUN with operands changed after capture
        if8.start = 1'b1; if8.a = 8'h3C; if8.b = 8'h0F; if8.cin = 1'b0;
        exp8_q.push_back(9'h04B);
        t8_q.push_back(cyc + 1 + 8);
        @(negedge clk);
        if8.a = 8'h00; if8.b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("held_busy", 32'(if8.busy), 32'd1);
            @(negedge clk);
        end
        chk("held_done", 32'(if8.done), 32'd1);
        exp8_q.push_back(9'h000);
        t8_q.push_back(cyc + 1 + 8);
        @(negedge clk);
        if8.start = 1'b0;
        chk("held_restart", 32'(if8.busy), 32'd1);
        wait_done8();
        @(negedge clk);

        // reset on the 4th RUN cycle after a known non-zero result
        issue8(8'h3C, 8'h0F, 1'b0, 1'b1);
        wait_done8();
        @(negedge clk);
        chk("pre_rst_sum", 32'(if8.sum), 32'h4B);
        issue8(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(if8.busy), 32'd0);
        chk("midrst_done", 32'(if8.done), 32'd0);
        chk("midrst_sum", 32'(if8.sum), 32'd0);
        chk("midrst_cout", 32'(if8.cout), 32'd0);
        chk("midrst_state", 32'(if8.state), 32'(IDLE));
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(if8.done), 32'd0);
        end

        // C8 + 64 + 1 = 0x12D, then 20 idle cycles with outputs held
        issue8(8'hC8, 8'h64, 1'b1, 1'b1);
        wait_done8();
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("hold_sum", 32'(if8.sum), 32'h2D);
            chk("hold_cout", 32'(if8.cout), 32'd1);
            chk("hold_done", 32'(if8.done), 32'd0);
            @(negedge clk);
        end

        // WIDTH=1 full adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            if1.start = 1'b1;
            if1.a     = v[2];
            if1.b     = v[1];
            if1.cin   = v[0];
            exp1_q.push_back(tbl1[i]);
            t1_q.push_back(cyc + 1 + 1);
            @(negedge clk);
            if1.start = 1'b0;
            wait_done1();
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue8_empty", 32'(exp8_q.size()), 32'd0);
        chk("queue1_empty", 32'(exp1_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
